share_recombiner: RTL
=====================

// Module: share_recombiner
// PURPOSE
// - Decoding end of the masked-multiplier datapath: accepts one 3-share Boolean-masked word per
//   handshake (e.g. the c0/c1/c2 outputs of the HPC2 AND gadget) and returns the unmasked value.
// - Shares are never combined combinationally at the inputs. Each share is first registered
//   (glitch barrier), then folded in two registered XOR stages.
// - Elastic valid/ready pipeline; sits between gadget outputs and unmasked consumers
//   (test harness, output port, checker).
// PARAMETERS
// - W      8   share/data width in bits (>=1)
// - CNT_W  16  width of the completed-transaction counter
// PORTS
// - clk        in   1      rising-edge clock
// - rst_n      in   1      asynchronous active-low reset
// - in_valid   in   1      share triple valid
// - in_ready   out  1      recombiner can accept this cycle
// - s0         in   W      share 0
// - s1         in   W      share 1
// - s2         in   W      share 2
// - out_valid  out  1      out_data valid
// - out_ready  in   1      consumer accepts out_data
// - out_data   out  W      s0^s1^s2 of the accepted triple
// - busy       out  1      any pipeline stage holds data
// - tx_count   out  CNT_W  number of completed output handshakes
// - rnd        in   W      refresh randomness; present only with SHARE_RECOMB_REFRESH_EN
// BEHAVIOUR
// Reset
// - Reset is asynchronous, active-low. While rst_n=0: all valid bits, out_valid, busy and
//   tx_count are 0, and all data registers are 0.
// - Assertion mid-operation discards all in-flight words immediately; no output follows.
// - in_ready is 1 one cycle after release.
// Stages
// - S1: registers r0=s0, r1=s1, r2=s2; valid bit v1.
// - S2: registers p=r0^r1 and q=r2; valid bit v2.
// - S3: output register out_data=p^q; valid bit v3=out_valid.
// Handshake rules
// - Input transfer when in_valid&&in_ready. Output transfer when out_valid&&out_ready.
// - adv3=out_ready, adv2=!v3||adv3, adv1=!v2||adv2, in_ready=!v1||adv1.
// - in_ready depends only on state and out_ready, never on in_valid.
// - Stage k loads from stage k-1 when adv_k. Its valid bit takes v_(k-1), or in_valid&&in_ready
//   for S1. Otherwise the stage holds data and valid unchanged.
// Latency and throughput
// - Latency is exactly 3 cycles from input transfer to out_valid when unstalled.
// - Throughput is 1 word/cycle with out_ready held at 1.
// Stalls
// - With out_ready=0 and out_valid=1, out_data must stay stable until transferred.
// - Pipeline fills to 3 words, then in_ready=0 until out_ready returns.
// - No word is lost or duplicated on simultaneous input/output transfer when full.
// Status outputs
// - busy = v1|v2|v3.
// - tx_count increments by 1 per output transfer and wraps modulo 2^CNT_W (0xFFFF -> 0x0000).
// Data-path rules
// - No share pair is XORed before both are registered.
// - s2 is never combined with s0 or s1 before stage 3.
// - Data registers load only on stage advance.
// CONFIGURATION
// - SHARE_RECOMB_REFRESH_EN defined:
//   - Port rnd exists.
//   - S1 instead captures r0=s0^rnd, r1=s1, r2=s2^rnd.
//   - rnd is sampled on the same input transfer as the shares.
//   - The unmasked result is unchanged; latency and handshake are unchanged.
// - Undefined:
//   - Port rnd is absent.
//   - S1 captures shares unmodified.
// TESTING
// - Reset, then s0=0x3C, s1=0xA5, s2=0x0F, one input transfer, out_ready=1
//   -> out_valid exactly 3 cycles later, out_data=0x96, tx_count=1.
// - 256 back-to-back triples, random s0/s1 with s2 chosen so the expected value is i, out_ready=1
//   -> 256 consecutive outputs 0x00..0xFF in order with no bubbles; busy falls 1 cycle after the
//   last transfer.
// - Stream with out_ready=0 for 10 cycles -> in_ready=0 after 3 words accepted; out_data stable;
//   on release all words arrive in order, none lost or duplicated.
// - Assert rst_n for 1 cycle with 2 words in flight -> out_valid=0 and busy=0 immediately;
//   tx_count=0; no stale output afterwards.
// - Preload tx_count to 0xFFFF via 65535 transfers, then 1 more transfer -> tx_count=0x0000.
// - With SHARE_RECOMB_REFRESH_EN, rnd random per word -> outputs identical to the run with the
//   macro undefined; with the macro undefined, rnd is absent from the port list (elaboration check).

Source files
------------

// File: rtl/share_recombiner.sv
// Three-stage elastic recombiner: registers each share, then folds them with two registered XOR stages.
// Optional define SHARE_RECOMB_REFRESH_EN adds port rnd and re-masks s0/s2 with it at capture.
module share_recombiner #(
    parameter int unsigned W     = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     s0,
    input  logic [W-1:0]     s1,
    input  logic [W-1:0]     s2,
`ifdef SHARE_RECOMB_REFRESH_EN
    input  logic [W-1:0]     rnd,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             busy,
    output logic [CNT_W-1:0] tx_count
);

    logic [W-1:0] r0, r1, r2;
    logic [W-1:0] p, q;
    logic         v1, v2;
    logic         adv1, adv2, adv3;
    logic [W-1:0] cap0, cap2;

    // rnd cancels in r0^r2, so the recombined value is unchanged
`ifdef SHARE_RECOMB_REFRESH_EN
    assign cap0 = s0 ^ rnd;
    assign cap2 = s2 ^ rnd;
`else
    assign cap0 = s0;
    assign cap2 = s2;
`endif

    assign adv3     = out_ready;
    assign adv2     = !out_valid || adv3;
    assign adv1     = !v2 || adv2;
    assign in_ready = !v1 || adv1;
    assign busy     = v1 | v2 | out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0        <= '0;
            r1        <= '0;
            r2        <= '0;
            v1        <= 1'b0;
            p         <= '0;
            q         <= '0;
            v2        <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            tx_count  <= '0;
        end else begin
            if (in_ready) begin
                r0 <= cap0;
                r1 <= s1;
                r2 <= cap2;
                v1 <= in_valid;
            end
            if (adv1) begin
                p  <= r0 ^ r1;
                q  <= r2;
                v2 <= v1;
            end
            if (adv2) begin
                out_data  <= p ^ q;
                out_valid <= v2;
            end
            if (out_valid && out_ready) begin
                tx_count <= tx_count + CNT_W'(1);
            end
        end
    end

endmodule
